// File: rtl/mcu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_regfile_pkg
// Description : Shared widths, types and a small index-match helper for the
//               integer register file.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_regfile_pkg;

   localparam int XLEN           = 32;
   localparam int RFIDX_WIDTH    = 5;
   localparam int RF_REG_NUM_DEF = 2 ** RFIDX_WIDTH;

   typedef logic [XLEN-1:0]        xlen_t;
   typedef logic [RFIDX_WIDTH-1:0] rfidx_t;

   // True when an enabled access targets a real (non-x0) register 'a' that equals 'b'.
   function automatic logic idx_hit(input logic en, input rfidx_t a, input rfidx_t b);
      return en && (a == b) && (a != '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcu_gnrl_dfflr.sv
`default_nettype none
// ============================================================================
// Module      : mcu_gnrl_dfflr
// Description : Generic load-enable flop with asynchronous active-low reset
//               to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_gnrl_dfflr #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   // Hold unless loaded; reset clears immediately without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qout <= '0;
      end else if (lden) begin
         qout <= dnxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mcu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mcu_regfile
// Description : Integer register file with one write-back port, two
//               combinational read ports, optional same-cycle write-back
//               forwarding and a per-register busy scoreboard for RAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_regfile
   import mcu_regfile_pkg::*;
#(
   parameter int RF_REG_NUM = RF_REG_NUM_DEF,
   parameter int RF_BYPASS  = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wbck_rf_ena,
   input  logic [XLEN-1:0]        wbck_rf_wdat,
   input  logic [RFIDX_WIDTH-1:0] wbck_rf_rdidx,
   input  logic                   disp_rd_set,
   input  logic [RFIDX_WIDTH-1:0] disp_rd_idx,
   input  logic [RFIDX_WIDTH-1:0] read_src1_idx,
   input  logic [RFIDX_WIDTH-1:0] read_src2_idx,
   output logic [XLEN-1:0]        read_src1_dat,
   output logic [XLEN-1:0]        read_src2_dat,
   output logic                   read_src1_busy,
   output logic                   read_src2_busy
);

   // Stored register contents; slot 0 is the hard-wired zero register.
   logic [RF_REG_NUM-1:0][XLEN-1:0] rf_q;

   // Busy scoreboard for x1..x(N-1); x0 is never busy.
   logic [RF_REG_NUM-1:1] busy_q;
   logic [RF_REG_NUM-1:1] busy_nxt;
   logic                  busy_lden;
   logic [RF_REG_NUM-1:0] busy_full;

   logic [XLEN-1:0] src1_stored;
   logic [XLEN-1:0] src2_stored;
   logic            src1_hit;
   logic            src2_hit;

   assign rf_q[0] = '0;

   // One load-enabled flop per architectural register; x0 writes are decoded away.
   for (genvar i = 1; i < RF_REG_NUM; i++) begin : g_reg
      logic wen;
      assign wen = wbck_rf_ena && (wbck_rf_rdidx == RFIDX_WIDTH'(i));

      mcu_gnrl_dfflr #(
         .DW (XLEN)
      ) u_reg (
         .clk   (clk),
         .rst_n (rst_n),
         .lden  (wen),
         .dnxt  (wbck_rf_wdat),
         .qout  (rf_q[i])
      );
   end

   // Scoreboard next state: write-back clears, dispatch sets, and a same-cycle set wins.
   always_comb begin
      busy_nxt = busy_q;
      for (int i = 1; i < RF_REG_NUM; i++) begin
         if (wbck_rf_ena && (wbck_rf_rdidx == RFIDX_WIDTH'(i))) begin
            busy_nxt[i] = 1'b0;
         end
         if (disp_rd_set && (disp_rd_idx == RFIDX_WIDTH'(i))) begin
            busy_nxt[i] = 1'b1;
         end
      end
   end

   assign busy_lden = disp_rd_set | wbck_rf_ena;

   mcu_gnrl_dfflr #(
      .DW (RF_REG_NUM - 1)
   ) u_busy (
      .clk   (clk),
      .rst_n (rst_n),
      .lden  (busy_lden),
      .dnxt  (busy_nxt),
      .qout  (busy_q)
   );

   assign busy_full = {busy_q, 1'b0};

   assign src1_stored = rf_q[read_src1_idx];
   assign src2_stored = rf_q[read_src2_idx];

   // Forwarding is qualified with rst_n so every read port shows zero while reset is held.
   if (RF_BYPASS != 0) begin : g_bypass
      assign src1_hit = rst_n && idx_hit(wbck_rf_ena, wbck_rf_rdidx, read_src1_idx);
      assign src2_hit = rst_n && idx_hit(wbck_rf_ena, wbck_rf_rdidx, read_src2_idx);
   end else begin : g_no_bypass
      assign src1_hit = 1'b0;
      assign src2_hit = 1'b0;
   end

   // A forwarded write-back both supplies the data and retires the pending producer.
   assign read_src1_dat  = src1_hit ? wbck_rf_wdat : src1_stored;
   assign read_src2_dat  = src2_hit ? wbck_rf_wdat : src2_stored;
   assign read_src1_busy = src1_hit ? 1'b0 : busy_full[read_src1_idx];
   assign read_src2_busy = src2_hit ? 1'b0 : busy_full[read_src2_idx];

endmodule
`default_nettype wire
